// File: rtl/spi_slave_core.sv
// SPI slave serializer/deserializer: oversamples SCLK/CS_N/MOSI in the clk domain and
// shifts 1..MAX_WORD-bit words in all four CPOL/CPHA modes with TX/RX valid/ready handshakes.
module spi_slave_core #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_WORD    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        cpol,
    input  logic        cpha,
    input  logic [5:0]  word_len,
    input  logic        lsb_first,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_overrun,
    output logic        tx_underrun,
    output logic        busy,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
);

    localparam int         IW      = (MAX_WORD > 1) ? $clog2(MAX_WORD) : 1;
    localparam logic [5:0] MAX_LEN = 6'(MAX_WORD);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                state_reg;
    logic [SYNC_STAGES-1:0] sclk_pipe_reg;
    logic [SYNC_STAGES-1:0] cs_pipe_reg;
    logic [SYNC_STAGES-1:0] mosi_pipe_reg;
    logic                  sclk_prev_reg;
    logic                  cs_prev_reg;

    logic [5:0]            bit_cnt_reg;
    logic [5:0]            len_reg;
    logic [MAX_WORD-1:0]   rx_sr_reg;
    logic [MAX_WORD-1:0]   tx_sr_reg;
    logic [MAX_WORD-1:0]   hold_reg;
    logic [MAX_WORD-1:0]   done_word_reg;
    logic                  hold_full_reg;
    logic                  done_reg;
    logic                  under_pend_reg;

    logic                  sclk_s;
    logic                  cs_s;
    logic                  mosi_s;
    logic                  sclk_chg;
    logic                  lead_edge;
    logic                  trail_edge;
    logic                  sample_edge;
    logic                  drive_edge;
    logic                  cs_fall;
    logic                  last_bit;
    logic                  load_now;
    logic [5:0]            eff_len;
    logic [IW-1:0]         first_idx;
    logic [IW-1:0]         cur_idx;
    logic [MAX_WORD-1:0]   load_word;
    logic [MAX_WORD-1:0]   rx_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_pipe_reg <= '0;
            cs_pipe_reg   <= '1;
            mosi_pipe_reg <= '0;
            sclk_prev_reg <= 1'b0;
            cs_prev_reg   <= 1'b1;
        end else begin
            sclk_pipe_reg <= {sclk_pipe_reg[SYNC_STAGES-2:0], spi_sclk};
            cs_pipe_reg   <= {cs_pipe_reg[SYNC_STAGES-2:0], spi_cs_n};
            mosi_pipe_reg <= {mosi_pipe_reg[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_reg <= sclk_s;
            cs_prev_reg   <= cs_s;
        end
    end

    assign sclk_s      = sclk_pipe_reg[SYNC_STAGES-1];
    assign cs_s        = cs_pipe_reg[SYNC_STAGES-1];
    assign mosi_s      = mosi_pipe_reg[SYNC_STAGES-1];
    assign sclk_chg    = sclk_s ^ sclk_prev_reg;
    assign lead_edge   = sclk_chg && (sclk_s != cpol);
    assign trail_edge  = sclk_chg && (sclk_s == cpol);
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign drive_edge  = cpha ? lead_edge : trail_edge;
    assign cs_fall     = cs_prev_reg && !cs_s;

    assign tx_ready    = !hold_full_reg;
    assign busy        = enable && !cs_s;

    always_comb begin
        eff_len = word_len;
        if (word_len == 6'd0) begin
            eff_len = 6'd8;
        end else if (word_len > MAX_LEN) begin
            eff_len = MAX_LEN;
        end
        load_word = hold_full_reg ? hold_reg : '0;
        first_idx = IW'(lsb_first ? 6'd0 : eff_len - 6'd1);
        cur_idx   = IW'(lsb_first ? bit_cnt_reg : len_reg - 6'd1 - bit_cnt_reg);
        if (lsb_first) begin
            rx_next = rx_sr_reg | ({{(MAX_WORD-1){1'b0}}, mosi_s} << bit_cnt_reg);
        end else begin
            rx_next = {rx_sr_reg[MAX_WORD-2:0], mosi_s};
        end
        last_bit = (bit_cnt_reg + 6'd1) == len_reg;
        load_now = !cs_s && ((state_reg == LOAD) ||
                             (state_reg == SHIFT && sample_edge && last_bit));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            len_reg        <= 6'd8;
            rx_sr_reg      <= '0;
            tx_sr_reg      <= '0;
            hold_reg       <= '0;
            done_word_reg  <= '0;
            hold_full_reg  <= 1'b0;
            done_reg       <= 1'b0;
            under_pend_reg <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            rx_overrun     <= 1'b0;
            tx_underrun    <= 1'b0;
            spi_miso       <= 1'b0;
            spi_miso_oe    <= 1'b0;
        end else begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            done_reg    <= 1'b0;
            if (!enable) begin
                state_reg      <= IDLE;
                bit_cnt_reg    <= '0;
                hold_full_reg  <= 1'b0;
                under_pend_reg <= 1'b0;
                rx_valid       <= 1'b0;
                spi_miso       <= 1'b0;
                spi_miso_oe    <= 1'b0;
            end else begin
                // Completed word is published one cycle after the final sample.
                if (done_reg) begin
                    if (rx_valid && !rx_ready) begin
                        rx_overrun <= 1'b1;
                    end else begin
                        rx_data  <= 32'(done_word_reg);
                        rx_valid <= 1'b1;
                    end
                end else if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end

                if (tx_valid && !hold_full_reg) begin
                    hold_reg      <= tx_data[MAX_WORD-1:0];
                    hold_full_reg <= 1'b1;
                end

                case (state_reg)
                    IDLE: begin
                        spi_miso_oe <= 1'b0;
                        bit_cnt_reg <= '0;
                        if (cs_fall) begin
                            state_reg <= LOAD;
                        end
                    end
                    LOAD: begin
                        state_reg <= cs_s ? IDLE : SHIFT;
                    end
                    SHIFT: begin
                        if (cs_s) begin
                            state_reg      <= IDLE;
                            spi_miso_oe    <= 1'b0;
                            bit_cnt_reg    <= '0;
                            under_pend_reg <= 1'b0;
                        end else if (sample_edge) begin
                            // An empty load only counts as underrun once the word actually starts.
                            if (under_pend_reg) begin
                                tx_underrun    <= 1'b1;
                                under_pend_reg <= 1'b0;
                            end
                            if (last_bit) begin
                                done_reg      <= 1'b1;
                                done_word_reg <= rx_next;
                            end else begin
                                rx_sr_reg   <= rx_next;
                                bit_cnt_reg <= bit_cnt_reg + 6'd1;
                            end
                        end else if (drive_edge) begin
                            spi_miso <= tx_sr_reg[cur_idx];
                        end
                    end
                    default: state_reg <= IDLE;
                endcase

                if (load_now) begin
                    tx_sr_reg      <= load_word;
                    rx_sr_reg      <= '0;
                    bit_cnt_reg    <= '0;
                    len_reg        <= eff_len;
                    spi_miso       <= load_word[first_idx];
                    spi_miso_oe    <= 1'b1;
                    under_pend_reg <= !hold_full_reg;
                    if (hold_full_reg) begin
                        hold_full_reg <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a bit-banged SPI master at clk/8 with hand-computed vectors.
module tb_spi_slave_core;

    logic        clk = 1'b0;
    logic        rst, enable, cpol, cpha, lsb_first;
    logic [5:0]  word_len;
    logic [31:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, rx_ready, rx_overrun, tx_underrun, busy;
    logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;

    int          n_chk = 0;
    int          n_bad = 0;
    int          ov_cnt = 0;
    int          un_cnt = 0;
    logic [31:0] rxq[$];

    always #5 clk = ~clk;

    spi_slave_core #(.SYNC_STAGES(2), .MAX_WORD(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cpol(cpol), .cpha(cpha),
        .word_len(word_len), .lsb_first(lsb_first),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .busy(busy),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
    );

    always @(negedge clk) begin
        if (rx_valid && rx_ready) rxq.push_back(rx_data);
        if (rx_overrun) ov_cnt++;
        if (tx_underrun) un_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic p, input logic h, input logic [5:0] len, input logic lsb);
        cpol = p; cpha = h; word_len = len; lsb_first = lsb;
        spi_sclk = p;
        tick(6);
    endtask

    task automatic cs_on();
        spi_cs_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_off();
        tick(4);
        spi_cs_n = 1'b1;
        tick(8);
    endtask

    task automatic push_tx(input logic [31:0] d);
        tx_data = d; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Master side: drives MOSI, samples MISO on the master's sample edge.
    task automatic xfer(input int n, input logic [31:0] mo, output logic [31:0] mi);
        mi = '0;
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = lsb_first ? i : n - 1 - i;
            if (!cpha) begin
                spi_mosi = mo[idx];
                tick(4);
                spi_sclk = ~cpol;
                mi[idx] = spi_miso;
                tick(4);
                spi_sclk = cpol;
            end else begin
                spi_sclk = ~cpol;
                spi_mosi = mo[idx];
                tick(4);
                spi_sclk = cpol;
                mi[idx] = spi_miso;
                tick(4);
            end
        end
    endtask

    initial begin
        logic [31:0] mi;
        int          base, ub, ob;
        logic        pol_tab [3];
        logic        pha_tab [3];
        pol_tab = '{1'b1, 1'b0, 1'b1};
        pha_tab = '{1'b1, 1'b1, 1'b0};

        rst = 1'b1; enable = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        word_len = 6'd8; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
        spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        tick(3);
        check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_rx_data", rx_data, 32'd0);
        check_eq("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(4);

        // Mode 0, 8-bit MSB first.
        set_mode(1'b0, 1'b0, 6'd8, 1'b0);
        base = rxq.size(); ub = un_cnt;
        push_tx(32'hA5);
        check_eq("t1_tx_ready_low", 32'(tx_ready), 32'd0);
        cs_on();
        xfer(8, 32'h3C, mi);
        cs_off();
        check_eq("t1_rx_count", 32'(rxq.size() - base), 32'd1);
        if (rxq.size() > base) check_eq("t1_rx_data", rxq[base], 32'h3C);
        check_eq("t1_miso_bits", mi, 32'hA5);
        check_eq("t1_underrun", 32'(un_cnt - ub), 32'd0);
        check_eq("t1_tx_ready_back", 32'(tx_ready), 32'd1);

        // 32-bit LSB-first in modes 3, 1, 2.
        for (int m = 0; m < 3; m++) begin
            set_mode(pol_tab[m], pha_tab[m], 6'd32, 1'b1);
            base = rxq.size(); ub = un_cnt;
            push_tx(32'hDEADBEEF);
            cs_on();
            xfer(32, 32'h12345678, mi);
            cs_off();
            check_eq($sformatf("t2_m%0d_rx", m), (rxq.size() > base) ? rxq[base] : 32'hX, 32'h12345678);
            check_eq($sformatf("t2_m%0d_miso", m), mi, 32'hDEADBEEF);
            check_eq($sformatf("t2_m%0d_underrun", m), 32'(un_cnt - ub), 32'd0);
        end

        // Three back-to-back 16-bit words, refill after the first.
        set_mode(1'b0, 1'b0, 6'd16, 1'b0);
        base = rxq.size(); ub = un_cnt;
        push_tx(32'hBEEF);
        cs_on();
        xfer(16, 32'hAAAA, mi);
        check_eq("t3_w1_miso", mi, 32'hBEEF);
        push_tx(32'h1234);
        xfer(16, 32'h5555, mi);
        check_eq("t3_w2_miso", mi, 32'h0000);
        xfer(16, 32'h0F0F, mi);
        check_eq("t3_w3_miso", mi, 32'h1234);
        cs_off();
        check_eq("t3_underrun", 32'(un_cnt - ub), 32'd1);
        check_eq("t3_rx_count", 32'(rxq.size() - base), 32'd3);
        if (rxq.size() >= base + 3) begin
            check_eq("t3_rx0", rxq[base], 32'hAAAA);
            check_eq("t3_rx1", rxq[base+1], 32'h5555);
            check_eq("t3_rx2", rxq[base+2], 32'h0F0F);
        end

        // Overrun with rx_ready held low.
        set_mode(1'b0, 1'b0, 6'd8, 1'b0);
        base = rxq.size(); ob = ov_cnt;
        rx_ready = 1'b0;
        cs_on();
        xfer(8, 32'h11, mi);
        xfer(8, 32'h22, mi);
        cs_off();
        check_eq("t4_rx_valid", 32'(rx_valid), 32'd1);
        check_eq("t4_rx_data", rx_data, 32'h11);
        check_eq("t4_overrun", 32'(ov_cnt - ob), 32'd1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(10);
        check_eq("t4_rx_valid_drop", 32'(rx_valid), 32'd0);
        check_eq("t4_rx_count", 32'(rxq.size() - base), 32'd1);
        rx_ready = 1'b1;

        // Partial frame then full word.
        base = rxq.size();
        cs_on();
        check_eq("t5_busy", 32'(busy), 32'd1);
        check_eq("t5_miso_oe_on", 32'(spi_miso_oe), 32'd1);
        xfer(5, 32'h1F, mi);
        cs_off();
        check_eq("t5_miso_oe_off", 32'(spi_miso_oe), 32'd0);
        check_eq("t5_no_partial", 32'(rxq.size() - base), 32'd0);
        cs_on();
        xfer(8, 32'h81, mi);
        cs_off();
        check_eq("t5_rx", (rxq.size() > base) ? rxq[base] : 32'hX, 32'h81);

        // word_len 0 -> 8 bits.
        set_mode(1'b0, 1'b0, 6'd0, 1'b0);
        base = rxq.size();
        push_tx(32'hC3);
        cs_on();
        xfer(8, 32'h5A, mi);
        cs_off();
        check_eq("t6_len0_rx", (rxq.size() > base) ? rxq[base] : 32'hX, 32'h5A);
        check_eq("t6_len0_miso", mi, 32'hC3);

        // word_len 40 -> 32 bits.
        set_mode(1'b0, 1'b0, 6'd40, 1'b0);
        base = rxq.size();
        push_tx(32'h87654321);
        cs_on();
        xfer(32, 32'hCAFEF00D, mi);
        cs_off();
        check_eq("t6_len40_rx", (rxq.size() > base) ? rxq[base] : 32'hX, 32'hCAFEF00D);
        check_eq("t6_len40_miso", mi, 32'h87654321);

        // enable=0 empties the holding register.
        push_tx(32'h55);
        check_eq("t7_tx_ready_full", 32'(tx_ready), 32'd0);
        enable = 1'b0;
        tick(2);
        check_eq("t7_tx_ready_empty", 32'(tx_ready), 32'd1);
        enable = 1'b1;
        tick(2);

        // Reset mid-word.
        set_mode(1'b0, 1'b0, 6'd8, 1'b0);
        push_tx(32'h77);
        cs_on();
        xfer(3, 32'h5, mi);
        rst = 1'b1;
        #2;
        check_eq("t8_rst_tx_ready", 32'(tx_ready), 32'd1);
        check_eq("t8_rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("t8_rst_rx_data", rx_data, 32'd0);
        check_eq("t8_rst_miso_oe", 32'(spi_miso_oe), 32'd0);
        check_eq("t8_rst_busy", 32'(busy), 32'd0);
        spi_cs_n = 1'b1; spi_sclk = cpol;
        tick(2);
        rst = 1'b0;
        tick(8);
        base = rxq.size();
        cs_on();
        xfer(8, 32'h96, mi);
        cs_off();
        check_eq("t8_recover_rx", (rxq.size() > base) ? rxq[base] : 32'hX, 32'h96);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
